// File: rtl/hdr_fetch_if.sv
// hdr_fetch_if: bus bundle for hdr_fetch.
//   ram_busy, rd_req, rd_address, rd_data, rd_data_valid : SDRAM arbiter read channel
//   pix_data, pix_valid, pix_ready                       : pixel-word stream to the display path
// The master modport is the fetch engine; the slave modport is the arbiter/consumer side.
interface hdr_fetch_if;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 128;

    logic              ram_busy;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        input  ram_busy,
        output rd_req,
        output rd_address,
        input  rd_data,
        input  rd_data_valid,
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        output ram_busy,
        input  rd_req,
        input  rd_address,
        output rd_data,
        output rd_data_valid,
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/hdr_fetch.sv
// hdr_fetch: reads completed HDR frames back from SDRAM (133 MHz domain) as single-word
// 128-bit requests, buffers the returns in a small FIFO and streams them as pixel words.
// Ports:
//   clk_133M, rst_n_133M   clock and asynchronous active-low reset
//   frame_start            pulse: start (or restart) fetching a frame
//   hdr_last_frame         store-side buffer toggle; the other buffer is read
//   bus (hdr_fetch_if)     arbiter read channel + pixel stream
//   frame_active           high from frame_start until the last word is popped
//   frame_restart          pulse when frame_start aborts an active frame
//   underflow_cnt          only with HDR_FETCH_UNDERFLOW_CNT_EN: saturating stall counter
// rd_req is a same-cycle qualification of ram_busy and the credit checks so that no request
// is ever presented while the arbiter is busy.
module hdr_fetch #(
    parameter int unsigned FRAME_WORDS     = 38400,
    parameter logic [24:0] BUF0_BASE       = 25'hE1000,
    parameter logic [24:0] BUF1_BASE       = 25'h106800,
    parameter logic [24:0] ADDR_STEP       = 25'd4,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_133M,
    input  logic        rst_n_133M,
    input  logic        frame_start,
    input  logic        hdr_last_frame,
    hdr_fetch_if.master bus,
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
    output logic [15:0] underflow_cnt,
`endif
    output logic        frame_active,
    output logic        frame_restart
);
    localparam int unsigned IC_W  = $clog2(FRAME_WORDS + 1);
    localparam int unsigned OS_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_next;
    logic [IC_W-1:0]   issue_cnt, pop_cnt;
    logic [OS_W-1:0]   outstanding, outstanding_next, discard_cnt;
    logic [FC_W-1:0]   fifo_count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [127:0]      mem [FIFO_DEPTH];
    logic [24:0]       rd_address_q;
    logic              pix_valid_q;

    logic              restart_c, ret_c, drop_c, push_c, pop_c, last_pop_c;
    logic              credit_ok_c, issue_c;
    logic [CR_W-1:0]   live_c;
    logic [FC_W-1:0]   fifo_count_next;

    // Return/stream handshakes; returns with nothing outstanding are stale and ignored.
    assign restart_c  = frame_start && (state != IDLE);
    assign ret_c      = bus.rd_data_valid && (outstanding != '0);
    assign drop_c     = ret_c && (discard_cnt != '0);
    assign push_c     = ret_c && (discard_cnt == '0) && !frame_start;
    assign pop_c      = pix_valid_q && bus.pix_ready;
    assign last_pop_c = pop_c && !frame_start && (pop_cnt == IC_W'(FRAME_WORDS - 1));

    // Credits: words still to be discarded never land in the FIFO, so they do not reserve space.
    assign live_c      = CR_W'(fifo_count) + CR_W'(outstanding - discard_cnt);
    assign credit_ok_c = (outstanding < OS_W'(MAX_OUTSTANDING)) && (live_c < CR_W'(FIFO_DEPTH));
    assign issue_c     = (state == ISSUE) && !frame_start && !bus.ram_busy &&
                         (issue_cnt < IC_W'(FRAME_WORDS)) && credit_ok_c;

    assign bus.rd_req     = issue_c;
    assign bus.rd_address = rd_address_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = mem[rd_ptr];

    // Outstanding-read bookkeeping.
    always_comb begin
        outstanding_next = outstanding;
        unique case ({issue_c, ret_c})
            2'b10:   outstanding_next = outstanding + OS_W'(1);
            2'b01:   outstanding_next = outstanding - OS_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    assign fifo_count_next = frame_start ? '0
                           : fifo_count + FC_W'(push_c) - FC_W'(pop_c);

    // State register.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) state <= IDLE;
        else             state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) state_next = ISSUE;
            end
            ISSUE: begin
                if (frame_start) state_next = ISSUE;
                else if (issue_c && (issue_cnt == IC_W'(FRAME_WORDS - 1))) state_next = DRAIN;
            end
            DRAIN: begin
                if (frame_start)     state_next = ISSUE;
                else if (last_pop_c) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, pointers, address and registered outputs.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            issue_cnt     <= '0;
            pop_cnt       <= '0;
            outstanding   <= '0;
            discard_cnt   <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_address_q  <= '0;
            pix_valid_q   <= 1'b0;
            frame_active  <= 1'b0;
            frame_restart <= 1'b0;
        end else begin
            outstanding   <= outstanding_next;
            fifo_count    <= fifo_count_next;
            pix_valid_q   <= (fifo_count_next != '0);
            frame_restart <= restart_c;
            if (frame_start) begin
                // Everything still in flight belongs to the aborted frame.
                discard_cnt  <= outstanding_next;
                rd_address_q <= hdr_last_frame ? BUF0_BASE : BUF1_BASE;
                issue_cnt    <= '0;
                pop_cnt      <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                frame_active <= 1'b1;
            end else begin
                if (drop_c)     discard_cnt  <= discard_cnt - OS_W'(1);
                if (issue_c)    rd_address_q <= rd_address_q + ADDR_STEP;
                if (issue_c)    issue_cnt    <= issue_cnt + IC_W'(1);
                if (pop_c)      pop_cnt      <= pop_cnt + IC_W'(1);
                if (push_c)     wr_ptr       <= wr_ptr + PTR_W'(1);
                if (pop_c)      rd_ptr       <= rd_ptr + PTR_W'(1);
                if (last_pop_c) frame_active <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk_133M) begin
        if (push_c) mem[wr_ptr] <= bus.rd_data;
    end

`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
    logic [15:0] underflow_q;

    // Cycles where the consumer is ready inside a frame but no word is available.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            underflow_q <= '0;
        end else if (frame_start) begin
            underflow_q <= '0;
        end else if (frame_active && bus.pix_ready && !pix_valid_q && (underflow_q != 16'hFFFF)) begin
            underflow_q <= underflow_q + 16'd1;
        end
    end

    assign underflow_cnt = underflow_q;
`endif
endmodule

// File: tb/tb_hdr_fetch.sv
// tb_hdr_fetch: scoreboard bench for hdr_fetch with a fixed-latency RAM model.
// Expected pixel words are queued when requests are seen and compared on each pop.
// Define HDR_FETCH_UNDERFLOW_CNT_EN to also cover the underflow counter.
module tb_hdr_fetch;
    localparam int FW = 24;
    localparam logic [24:0] B0 = 25'hE1000;
    localparam logic [24:0] B1 = 25'h106800;

    typedef struct {
        int           due;
        logic [127:0] data;
    } ram_rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic hdr_last_frame = 1'b0;
    logic frame_active, frame_restart;
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
    logic [15:0] exp_uf = '0;
`endif

    hdr_fetch_if bus ();

    hdr_fetch #(.FRAME_WORDS(FW)) dut (
        .clk_133M      (clk),
        .rst_n_133M    (rst_n),
        .frame_start   (frame_start),
        .hdr_last_frame(hdr_last_frame),
        .bus           (bus),
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
`endif
        .frame_active  (frame_active),
        .frame_restart (frame_restart)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           ram_lat = 2;
    int           reqs = 0;
    int           pops = 0;
    bit           sb_active = 0;
    bit           fa_check = 0;
    logic [24:0]  exp_addr = '0;
    ram_rsp_t     ramq[$];
    logic [127:0] pixq[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] word_of(input logic [24:0] a);
        return {39'h0, a, 32'hDEAD_BEEF ^ 32'(a), 7'h0, a};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: returns each request ram_lat cycles after it was issued, in order.
    always @(posedge clk) begin
        #1;
        bus.rd_data_valid = 1'b0;
        if (rst_n && ramq.size() != 0 && ramq[0].due <= cyc) begin
            bus.rd_data       = ramq[0].data;
            bus.rd_data_valid = 1'b1;
            void'(ramq.pop_front());
        end
    end

    // Monitor: requests feed the RAM model and the expected-pixel queue; pops are scored.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fa_check) begin
                check_eq("frame_active_fall", 128'(frame_active), 128'(0));
                fa_check = 0;
            end
            if (bus.ram_busy) check_eq("req_while_busy", 128'(bus.rd_req), 128'(0));
            if (bus.rd_req) begin
                check_eq("rd_address", 128'(bus.rd_address), 128'(exp_addr));
                check_eq("req_in_frame", 128'(reqs < FW), 128'(1));
                ramq.push_back('{due: cyc + ram_lat, data: word_of(bus.rd_address)});
                pixq.push_back(word_of(exp_addr));
                exp_addr = exp_addr + 25'd4;
                reqs++;
            end
            if (bus.pix_valid && bus.pix_ready && !frame_start) begin
                check_eq("frame_active_hold", 128'(frame_active), 128'(1));
                check_eq("pix_expected", 128'(pixq.size() != 0), 128'(1));
                if (pixq.size() != 0) check_eq("pix_data", bus.pix_data, pixq.pop_front());
                pops++;
                if (pops == FW) begin
                    sb_active = 0;
                    fa_check  = 1;
                end
            end
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
            if (frame_start) exp_uf = '0;
            else if (frame_active && bus.pix_ready && !bus.pix_valid && exp_uf != 16'hFFFF)
                exp_uf = exp_uf + 16'd1;
`endif
        end
    end

    task automatic start_frame(input logic hlf);
        bit exp_restart;
        exp_restart    = sb_active;
        exp_addr       = hlf ? B0 : B1;
        pixq.delete();
        reqs           = 0;
        pops           = 0;
        sb_active      = 1;
        hdr_last_frame = hlf;
        frame_start    = 1'b1;
        tick(1);
        frame_start    = 1'b0;
        check_eq("frame_restart", 128'(frame_restart), 128'(exp_restart));
        check_eq("frame_active_rise", 128'(frame_active), 128'(1));
        tick(1);
        check_eq("frame_restart_pulse", 128'(frame_restart), 128'(0));
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (pops < FW && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("frame_done", 128'(pops), 128'(FW));
        tick(3);
        check_eq("frame_reqs", 128'(reqs), 128'(FW));
        check_eq("frame_idle", 128'(frame_active), 128'(0));
    endtask

    task automatic wait_reqs(input int target, input int budget);
        int n = 0;
        while (reqs < target && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("reqs_reached", 128'(reqs >= target), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_req"}, 128'(bus.rd_req), 128'(0));
        check_eq({tag, "_rd_address"}, 128'(bus.rd_address), 128'(0));
        check_eq({tag, "_pix_valid"}, 128'(bus.pix_valid), 128'(0));
        check_eq({tag, "_frame_active"}, 128'(frame_active), 128'(0));
        check_eq({tag, "_frame_restart"}, 128'(frame_restart), 128'(0));
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
        check_eq({tag, "_underflow_cnt"}, 128'(underflow_cnt), 128'(0));
`endif
    endtask

    initial begin
        int r0;
        bus.ram_busy  = 1'b0;
        bus.pix_ready = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Normal frame from buffer 0, RAM latency 2.
        ram_lat = 2;
        start_frame(1'b1);
        wait_frame(1000);

        // Buffer 1 selected when the store side is on buffer 0.
        start_frame(1'b0);
        wait_frame(1000);

        // Consumer stalled: FIFO credit caps requests at the FIFO depth.
        ram_lat       = 1;
        bus.pix_ready = 1'b0;
        start_frame(1'b1);
        tick(60);
        check_eq("credit_stop_16", 128'(reqs), 128'(16));
        bus.pix_ready = 1'b1;
        tick(4);
        bus.pix_ready = 1'b0;
        check_eq("pops_4", 128'(pops), 128'(4));
        tick(30);
        check_eq("credit_stop_20", 128'(reqs), 128'(20));
        bus.pix_ready = 1'b1;
        wait_frame(1000);

        // Arbiter busy for 10 cycles mid-frame.
        ram_lat = 2;
        start_frame(1'b0);
        wait_reqs(6, 200);
        bus.ram_busy = 1'b1;
        r0 = reqs;
        tick(10);
        check_eq("busy_no_req", 128'(reqs), 128'(r0));
        bus.ram_busy = 1'b0;
        wait_frame(1000);

        // Restart with 4 reads in flight: late returns must be dropped.
        ram_lat = 12;
        start_frame(1'b1);
        wait_reqs(4, 200);
        tick(2);
        check_eq("restart_inflight", 128'(ramq.size()), 128'(4));
        start_frame(1'b0);
        wait_frame(2000);

        // Slow RAM: consumer stalls occur.
        ram_lat = 6;
        start_frame(1'b1);
        wait_frame(2000);
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
        check_eq("underflow_cnt", 128'(underflow_cnt), 128'(exp_uf));
        check_eq("underflow_nonzero", 128'(underflow_cnt != 16'h0), 128'(1));
`endif

        // Asynchronous reset in the middle of a frame.
        ram_lat = 3;
        start_frame(1'b0);
        wait_reqs(5, 200);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ramq.delete();
        pixq.delete();
        sb_active = 0;
`ifdef HDR_FETCH_UNDERFLOW_CNT_EN
        exp_uf = '0;
`endif
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Recovery after reset.
        ram_lat = 2;
        start_frame(1'b1);
        wait_frame(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
